// File: rtl/shift_add_mul_ctrl.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier: one shared ripple-carry adder, one multiplier bit per cycle.
// Optional feature macro ZERO_BYPASS_EN: a zero operand skips the RUN phase and finishes in one cycle.
module shift_add_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic [2*WIDTH-1:0] r_p;

  logic               w_zero_op;
  logic               w_last;
  logic               w_load;
  logic               w_shift;
  logic               w_finish;
  logic               w_busy;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH:0]     w_carry;

`ifdef ZERO_BYPASS_EN
  assign w_zero_op = (a == '0) || (b == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Shared adder: ACC + (Q[0] ? M : 0), carry-in tied low.
  always_comb begin
    w_addend   = r_q[0] ? r_m : '0;
    w_carry[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i]       = r_acc[i] ^ w_addend[i] ^ w_carry[i];
      w_carry[i + 1] = (r_acc[i] & w_addend[i]) | (w_carry[i] & (r_acc[i] ^ w_addend[i]));
    end
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next defaults to the current state first, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_zero_op ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_load   = (r_state == S_IDLE) && start;
    w_shift  = (r_state == S_RUN);
    w_finish = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m    <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_p    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_m   <= a;
        r_q   <= w_zero_op ? '0 : b;
        r_acc <= '0;
        r_cnt <= '0;
      end
      // Carry-out drops into the ACC MSB while the low product bit shifts into Q.
      if (w_shift) begin
        {r_acc, r_q} <= {w_carry[WIDTH], w_sum, r_q[WIDTH-1:1]};
        r_cnt        <= r_cnt + CW'(1);
      end
      if (w_finish) begin
        r_p    <= {r_acc, r_q};
        r_done <= 1'b1;
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign p    = r_p;

endmodule
